// File: rtl/filter_pkg.sv
// Shared types, default mask geometry and window-count helper for the filter window controller.
package filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int MASK_WIDTH = 7;
    localparam int HALF       = (MASK_WIDTH - 1) / 2;

    // Number of interior windows one frame produces.
    function automatic int window_count(input int img_width, input int img_height,
                                        input int mask_width);
        return (img_width - mask_width + 1) * (img_height - mask_width + 1);
    endfunction

endpackage

// File: rtl/filter_window_ctrl_pos.sv
// Raster position counter: col runs 0..IMG_WIDTH-1, row advances on col wrap,
// and the whole position wraps to (0,0) after the last pixel of the frame.
module pixel_pos_counter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_BIT    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [CNT_BIT-1:0] row,
    output logic [CNT_BIT-1:0] col,
    output logic               last
);

    localparam logic [CNT_BIT-1:0] COL_MAX = CNT_BIT'(IMG_WIDTH - 1);
    localparam logic [CNT_BIT-1:0] ROW_MAX = CNT_BIT'(IMG_HEIGHT - 1);

    logic col_end;

    assign col_end = (col == COL_MAX);
    assign last    = col_end && (row == ROW_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col_end) begin
                col <= '0;
                row <= last ? '0 : row + CNT_BIT'(1);
            end else begin
                col <= col + CNT_BIT'(1);
            end
        end
    end

endmodule

// File: rtl/filter_window_ctrl.sv
// Sliding-window controller: tracks raster position, flags interior windows and
// hands them to the filter with a valid/ready handshake. Define FILTER_CTRL_ERR_EN
// to build the sticky start-while-busy error detector.
//
// state  | meaning
// IDLE   | waiting for start
// ACTIVE | accepting pixels of the frame
// DRAIN  | last pixel taken, waiting for the final window to be consumed
// DONE   | one-cycle frame_done pulse
module filter_window_ctrl #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = filter_pkg::MASK_WIDTH,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_BIT    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic               shift_en,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [CNT_BIT-1:0] center_row,
    output logic [CNT_BIT-1:0] center_col,
    output logic               busy,
    output logic               frame_done,
    output logic               err
);

    import filter_pkg::*;

    localparam int HALF_W = (MASK_WIDTH - 1) / 2;
    localparam logic [CNT_BIT-1:0] EDGE   = CNT_BIT'(MASK_WIDTH - 1);
    localparam logic [CNT_BIT-1:0] HALF_C = CNT_BIT'(HALF_W);

    if (PIX_BIT < 1 || MASK_WIDTH < 3 || (MASK_WIDTH % 2) == 0 ||
        IMG_WIDTH < MASK_WIDTH || IMG_HEIGHT < MASK_WIDTH ||
        (2 ** CNT_BIT) < IMG_WIDTH || (2 ** CNT_BIT) < IMG_HEIGHT ||
        window_count(IMG_WIDTH, IMG_HEIGHT, MASK_WIDTH) < 1) begin : g_bad_params
        $error("filter_window_ctrl: illegal parameter combination");
    end

    state_t             state;
    state_t             state_next;
    logic [CNT_BIT-1:0] row;
    logic [CNT_BIT-1:0] col;
    logic               last;
    logic               clr;
    logic               interior;

    pixel_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .CNT_BIT    (CNT_BIT)
    ) u_pos (
        .clk   (clk),
        .reset (reset),
        .inc   (shift_en),
        .clr   (clr),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    assign clr      = (state == ST_IDLE) && start;
    assign interior = (row >= EDGE) && (col >= EDGE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_ACTIVE;
            ST_ACTIVE: if (shift_en && last) state_next = ST_DRAIN;
            ST_DRAIN:  if (!win_valid || win_ready) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE);
        pix_ready  = (state == ST_ACTIVE) && (!win_valid || win_ready);
        shift_en   = pix_valid && pix_ready;
    end

    // A new pixel can only be taken when any pending window is consumed in the
    // same cycle, so shift_en alone decides the next window flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid  <= 1'b0;
            center_row <= '0;
            center_col <= '0;
        end else if (shift_en) begin
            win_valid <= interior;
            if (interior) begin
                center_row <= row - HALF_C;
                center_col <= col - HALF_C;
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

`ifdef FILTER_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (start && busy) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Randomized bench for filter_window_ctrl (10x8 frame and 7x7 corner case)
// against a raster-order reference model.
module tb_filter_window_ctrl;

    localparam int W  = 10;
    localparam int H  = 8;
    localparam int M  = 7;
    localparam int HF = (M - 1) / 2;
    localparam int CB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, start = 1'b0, pix_valid = 1'b0, win_ready = 1'b0;
    logic pix_ready, shift_en, win_valid, busy, frame_done, err;
    logic [CB-1:0] center_row, center_col;

    logic start7 = 1'b0, pix_valid7 = 1'b0, win_ready7 = 1'b0;
    logic pix_ready7, shift_en7, win_valid7, busy7, frame_done7, err7;
    logic [CB-1:0] center_row7, center_col7;

    filter_window_ctrl #(.PIX_BIT(8), .MASK_WIDTH(M), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                         .CNT_BIT(CB)) dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .shift_en(shift_en), .win_valid(win_valid),
        .win_ready(win_ready), .center_row(center_row), .center_col(center_col),
        .busy(busy), .frame_done(frame_done), .err(err));

    filter_window_ctrl #(.PIX_BIT(8), .MASK_WIDTH(M), .IMG_WIDTH(7), .IMG_HEIGHT(7),
                         .CNT_BIT(CB)) dut7 (
        .clk(clk), .reset(reset), .start(start7), .pix_valid(pix_valid7),
        .pix_ready(pix_ready7), .shift_en(shift_en7), .win_valid(win_valid7),
        .win_ready(win_ready7), .center_row(center_row7), .center_col(center_col7),
        .busy(busy7), .frame_done(frame_done7), .err(err7));

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 active, 2 drain, 3 done
    int phase = 0, n_acc = 0, m_wv = 0, m_cr = 0, m_cc = 0, m_err = 0, fd_seen = 0;
    int got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic pv, input logic wr, input logic st);
        logic e_ready, e_shift;
        int   r, c, nxt;
        @(negedge clk);
        pix_valid = pv;
        win_ready = wr;
        start     = st;
        #1;
        e_ready = (phase == 1) && (m_wv == 0 || wr);
        e_shift = pv && e_ready;
        chk("pix_ready", pix_ready, e_ready);
        chk("shift_en", shift_en, e_shift);
        chk("win_valid", win_valid, m_wv != 0);
        chk("busy", busy, phase != 0);
        chk("frame_done", frame_done, phase == 3);
        chk("err", err, m_err != 0);
        if (m_wv != 0) begin
            chk("center_row", center_row, m_cr);
            chk("center_col", center_col, m_cc);
        end
        if (frame_done) fd_seen++;
        if (win_valid && wr) got_q.push_back(int'(center_row) * 256 + int'(center_col));

        nxt = phase;
        case (phase)
            0:       if (st) begin nxt = 1; n_acc = 0; end
            1:       if (e_shift && n_acc == W * H - 1) nxt = 2;
            2:       if (m_wv == 0 || wr) nxt = 3;
            default: nxt = 0;
        endcase
`ifdef FILTER_CTRL_ERR_EN
        if (phase != 0 && st) m_err = 1;
`endif
        if (e_shift) begin
            r = n_acc / W;
            c = n_acc % W;
            if (r >= M - 1 && c >= M - 1) begin
                m_wv = 1; m_cr = r - HF; m_cc = c - HF;
            end else begin
                m_wv = 0;
            end
            n_acc++;
        end else if (wr) begin
            m_wv = 0;
        end
        phase = nxt;
    endtask

    task automatic do_reset(input logic st);
        @(negedge clk);
        reset = 1'b1; start = st; start7 = st;
        pix_valid = 1'b0; win_ready = 1'b0; pix_valid7 = 1'b0; win_ready7 = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; start7 = 1'b0;
        phase = 0; n_acc = 0; m_wv = 0; m_cr = 0; m_cc = 0; m_err = 0;
        #1;
        chk("rst_win_valid", win_valid, 0);
        chk("rst_center_row", center_row, 0);
        chk("rst_center_col", center_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_busy7", busy7, 0);
    endtask

    task automatic run_frame(input int pv_pct, input int wr_pct, input int hold_first,
                             input int start_at);
        int   cyc, held, idx;
        int   exp_q[$];
        logic pv, wr, st;
        got_q.delete();
        fd_seen = 0;
        cycle(1'b0, 1'b0, 1'b1);
        cyc = 0; held = 0;
        while (phase != 0 && cyc < 4000) begin
            pv = ($urandom_range(0, 99) < pv_pct);
            wr = ($urandom_range(0, 99) < wr_pct);
            st = (cyc == start_at);
            if (hold_first != 0 && m_wv != 0 && got_q.size() == 0 && held < 5) begin
                pv = 1'b1; wr = 1'b0; held++;
                cycle(pv, wr, st);
                chk("hold_pix_ready", pix_ready, 0);
                chk("hold_center", int'(center_row) * 256 + int'(center_col), HF * 256 + HF);
            end else begin
                cycle(pv, wr, st);
            end
            cyc++;
        end
        chk("frame_in_budget", cyc < 4000, 1);
        if (hold_first != 0) chk("hold_cycles", held, 5);
        for (int r = HF; r <= H - 1 - HF; r++)
            for (int c = HF; c <= W - 1 - HF; c++)
                exp_q.push_back(r * 256 + c);
        chk("window_count", got_q.size(), (W - M + 1) * (H - M + 1));
        idx = 0;
        foreach (exp_q[i]) begin
            if (i < got_q.size()) chk("window_order", got_q[i], exp_q[i]);
            idx++;
        end
        chk("frame_done_count", fd_seen, 1);
    endtask

    int n7, hs7, fd7, wins7, fds7, stall7;

    initial begin
        int cyc;
        do_reset(1'b0);

        // idle: pix_valid must be ignored
        repeat (4) cycle(1'b1, 1'b1, 1'b0);

        // full-throughput frame, then random backpressure frames
        run_frame(100, 100, 0, -1);
        run_frame(70, 60, 0, -1);
        run_frame(50, 40, 0, -1);

        // stall at first window
        run_frame(100, 100, 1, -1);

        // start pulsed mid-frame
        run_frame(80, 80, 0, 20);
        chk("err_after_busy_start", err,
`ifdef FILTER_CTRL_ERR_EN
            1
`else
            0
`endif
        );

        // reset after 40 accepted pixels, with start held during reset
        cycle(1'b0, 1'b0, 1'b1);
        cyc = 0;
        while (n_acc < 40 && cyc < 1000) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
            cyc++;
        end
        chk("midframe_reached_40", n_acc, 40);
        do_reset(1'b1);
        run_frame(75, 75, 0, -1);

        // 7x7 frame: one window, frame_done after its handshake
        @(negedge clk);
        start7 = 1'b1;
        n7 = 0; hs7 = -1; fd7 = -1; wins7 = 0; fds7 = 0; stall7 = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            start7 = 1'b0;
            pix_valid7 = 1'b1;
            if (win_valid7 && stall7 < 3) begin
                win_ready7 = 1'b0; stall7++;
            end else begin
                win_ready7 = 1'b1;
            end
            #1;
            if (shift_en7) n7++;
            if (win_valid7 && win_ready7) begin
                wins7++; hs7 = k;
                chk("w7_center_row", center_row7, HF);
                chk("w7_center_col", center_col7, HF);
            end
            if (frame_done7) begin
                fds7++;
                if (fd7 < 0) fd7 = k;
            end
        end
        pix_valid7 = 1'b0;
        chk("w7_windows", wins7, 1);
        chk("w7_pixels", n7, 49);
        chk("w7_stall", stall7, 3);
        chk("w7_frame_done_count", fds7, 1);
        chk("w7_fd_after_handshake", fd7 - hs7, 1);
        chk("w7_err", err7, 0);
        chk("w7_busy_end", busy7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_window_ctrl.md
FILTER_WINDOW_CTRL -- requirements
Module: filter_window_ctrl

Interface
REQ-001 SHALL have parameter PIX_BIT, default 8, pixel width (passed through for the package; no datapath use).
REQ-002 SHALL have parameter MASK_WIDTH, default 7, mask width; odd and at least 3; HALF = (MASK_WIDTH-1)/2.
REQ-003 SHALL have parameter IMG_WIDTH, default 640, pixels per row; at least MASK_WIDTH.
REQ-004 SHALL have parameter IMG_HEIGHT, default 480, rows per frame; at least MASK_WIDTH.
REQ-005 SHALL have parameter CNT_BIT, default 10, coordinate counter width; 2**CNT_BIT must be at least max(IMG_WIDTH, IMG_HEIGHT).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle frame start request.
REQ-009 SHALL have port pix_valid, input, 1, incoming pixel column present.
REQ-010 SHALL have port pix_ready, output, 1, controller accepts the pixel column.
REQ-011 SHALL have port shift_en, output, 1, advance the window registers and line buffers (accepted pixel).
REQ-012 SHALL have port win_valid, output, 1, window registers hold a complete interior 7x7 window.
REQ-013 SHALL have port win_ready, input, 1, filter function consumes the window.
REQ-014 SHALL have port center_row, output, CNT_BIT, row of the window centre pixel.
REQ-015 SHALL have port center_col, output, CNT_BIT, column of the window centre pixel.
REQ-016 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-017 SHALL have port frame_done, output, 1, one-cycle end-of-frame pulse.
REQ-018 SHALL have port err, output, 1, sticky protocol error flag (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, ACTIVE, DRAIN, DONE.
REQ-020 IDLE to ACTIVE SHALL occur on start=1, clearing row=0 and col=0; start in any other state SHALL NOT alter the FSM.
REQ-021 pix_ready SHALL equal (state==ACTIVE) & (!win_valid | win_ready); shift_en SHALL equal pix_valid & pix_ready, combinationally.
REQ-022 Each shift_en SHALL increment col; at col==IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 Accepting pixel (r,c) with r>=MASK_WIDTH-1 and c>=MASK_WIDTH-1 SHALL set win_valid on the next cycle, with center_row=r-HALF and center_col=c-HALF registered on that same edge.
REQ-024 Accepting any other pixel SHALL clear win_valid on the next cycle if it was consumed; a window never spans a row wrap.
REQ-025 win_valid and the center coordinates SHALL hold stable while win_valid=1 and win_ready=0; a window and a new pixel SHALL transfer in the same cycle (throughput 1/cycle).
REQ-026 Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL move ACTIVE to DRAIN.
REQ-027 DRAIN SHALL move to DONE in the cycle win_valid=0 or win_ready=1.
REQ-028 DONE SHALL assert frame_done for exactly one cycle, then return to IDLE.
REQ-029 Each frame SHALL produce exactly (IMG_WIDTH-MASK_WIDTH+1)*(IMG_HEIGHT-MASK_WIDTH+1) windows, in raster order.
REQ-030 pix_valid outside ACTIVE SHALL be ignored, with pix_ready=0.

Reset
REQ-031 On reset, including mid-frame, the block SHALL force state=IDLE, row=0, col=0, win_valid=0, center_row=0, center_col=0, frame_done=0, err=0, busy=0.
REQ-032 Reset SHALL override start in the same cycle.

Configuration
REQ-033 With FILTER_CTRL_ERR_EN defined, err SHALL set one cycle after start=1 while busy=1, and SHALL stay set until reset.
REQ-034 Without FILTER_CTRL_ERR_EN, err SHALL be constant 0 and no detection logic SHALL be built; start is still ignored while busy.

Structure
REQ-035 filter_pkg SHALL hold the state enum, the MASK_WIDTH and HALF constants, and the window-count function.
REQ-036 The row/col counters SHALL be one sub-module, pixel_pos_counter (inputs: inc, clr; outputs: row, col, last).

Verification (W=10, H=8, MASK_WIDTH=7 unless noted)
REQ-037 start, then 80 pixels with win_ready=1 held -> 8 windows; centres (3,3)..(3,6),(4,3)..(4,6); frame_done once.
REQ-038 win_ready=0 for 5 cycles at the first window -> pix_ready=0 and centre (3,3) held stable; resumes without loss.
REQ-039 reset asserted after 40 pixels -> all outputs 0 next cycle; a new start gives a full 8-window frame.
REQ-040 start pulsed during ACTIVE -> frame unaffected; err=1 with FILTER_CTRL_ERR_EN, 0 without.
REQ-041 pix_valid=1 in IDLE -> pix_ready=0, shift_en=0, counters unchanged.
REQ-042 W=H=7 -> exactly 1 window, centre (3,3); frame_done follows its handshake.
